// File: rtl/si4463_spi_pkg.sv
// rtl/si4463_spi_pkg.sv - shared types and constants for the Si4463 command sequencer
package si4463_spi_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEL,
      ST_SS_ON,
      ST_TX_WAIT,
      ST_TX_WR,
      ST_RX_WAIT,
      ST_RX_RD,
      ST_SS_OFF_WAIT,
      ST_SS_OFF,
      ST_GAP,
      ST_POLL_ON,
      ST_FIN
   } seq_state_t;

   // Which kind of SSO frame is currently open
   typedef enum logic {
      FR_CMD,
      FR_POLL
   } frame_t;

   localparam logic [2:0] REG_RXDATA   = 3'd0;
   localparam logic [2:0] REG_TXDATA   = 3'd1;
   localparam logic [2:0] REG_CONTROL  = 3'd3;
   localparam logic [2:0] REG_SLAVESEL = 3'd5;

   localparam int SSO_BIT = 10;
   localparam logic [15:0] CTRL_SSO = 16'h0001 << SSO_BIT;

   localparam logic [7:0] READ_CMD_BUFF = 8'h44;
   localparam logic [7:0] CTS_READY     = 8'hFF;
   localparam logic [7:0] DUMMY         = 8'hFF;

   // Clamp a host length to the buffer depth; optionally promote 0 to 1
   function automatic logic [4:0] clamp_len(input logic [4:0] len, input int depth,
                                            input logic min_one);
      logic [4:0] r;
      r = len;
      if (int'(len) > depth) r = 5'(depth);
      if (min_one && (len == 5'd0)) r = 5'd1;
      return r;
   endfunction

endpackage

// File: rtl/spi_reg_access.sv
// rtl/spi_reg_access.sv - two-cycle SPI master register access followed by one idle cycle
module spi_reg_access (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [15:0] wdata,
   output logic        ack,
   output logic [15:0] rdata,
   output logic        spi_select,
   output logic [2:0]  mem_addr,
   output logic        write_n,
   output logic        read_n,
   output logic [15:0] spi_wdata,
   input  logic [15:0] spi_rdata
);

   // 0 idle, 1 first strobe cycle, 2 second strobe cycle, 3 idle cycle with ack
   logic [1:0] phase;

   // Bus outputs are registered so they stay glitch-free and stable for the whole access
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase      <= 2'd0;
         spi_select <= 1'b0;
         write_n    <= 1'b1;
         read_n     <= 1'b1;
         mem_addr   <= 3'd0;
         spi_wdata  <= 16'h0000;
         rdata      <= 16'h0000;
      end else begin
         case (phase)
            2'd0: begin
               if (req) begin
                  phase      <= 2'd1;
                  spi_select <= 1'b1;
                  write_n    <= !we;
                  read_n     <= we;
                  mem_addr   <= addr;
                  spi_wdata  <= wdata;
               end
            end
            2'd1: phase <= 2'd2;
            2'd2: begin
               phase      <= 2'd3;
               spi_select <= 1'b0;
               write_n    <= 1'b1;
               read_n     <= 1'b1;
               rdata      <= spi_rdata;
            end
            default: phase <= 2'd0;
         endcase
      end
   end

   assign ack = (phase == 2'd3);

endmodule

// File: rtl/si4463_cmd_seq.sv
// rtl/si4463_cmd_seq.sv - Si4463 command/CTS-poll/response sequencer over the SPI master register port
module si4463_cmd_seq
   import si4463_spi_pkg::*;
#(
   parameter int BUF_DEPTH  = 16,
   parameter int MAX_POLLS  = 255,
   parameter int GAP_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_wr,
   input  logic [3:0]  cmd_addr,
   input  logic [7:0]  cmd_wdata,
   input  logic [4:0]  cmd_len,
   input  logic [4:0]  resp_len,
   input  logic        cts_en,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic [3:0]  resp_addr,
   output logic [7:0]  resp_rdata,
   output logic        spi_select,
   output logic [2:0]  mem_addr,
   output logic        write_n,
   output logic        read_n,
   output logic [15:0] spi_wdata,
   input  logic [15:0] spi_rdata,
   input  logic        dataavailable,
   input  logic        transmitterempty
);

   localparam int PW = $clog2(MAX_POLLS + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   seq_state_t     state, nxt;
   frame_t         frame;
   logic [4:0]     idx, cmd_len_q, resp_len_q;
   logic           cts_en_q, cts_ok;
   logic [PW-1:0]  poll_cnt;
   logic [GW-1:0]  gap_cnt;
   logic [7:0]     cmd_buf  [BUF_DEPTH];
   logic [7:0]     resp_buf [BUF_DEPTH];

   logic           acc_req, acc_we, acc_ack;
   logic [2:0]     acc_addr;
   logic [15:0]    acc_wdata, acc_rdata;
   logic [7:0]     tx_byte, rx_byte;
   logic           last_byte, gap_done, poll_timeout;
   logic           unused_rdata_hi;

   spi_reg_access u_acc (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (acc_req),
      .we         (acc_we),
      .addr       (acc_addr),
      .wdata      (acc_wdata),
      .ack        (acc_ack),
      .rdata      (acc_rdata),
      .spi_select (spi_select),
      .mem_addr   (mem_addr),
      .write_n    (write_n),
      .read_n     (read_n),
      .spi_wdata  (spi_wdata),
      .spi_rdata  (spi_rdata)
   );

   assign rx_byte         = acc_rdata[7:0];
   assign unused_rdata_hi = ^acc_rdata[15:8];
   assign gap_done        = (gap_cnt == GW'(GAP_CYCLES - 1));
   assign poll_timeout    = (frame == FR_POLL) && !cts_ok && (poll_cnt == PW'(MAX_POLLS - 1));
   assign resp_rdata      = resp_buf[resp_addr];

   // Byte to shift out and whether the byte just received closes the current frame
   always_comb begin
      tx_byte   = DUMMY;
      last_byte = 1'b0;
      if (frame == FR_CMD) begin
         tx_byte   = cmd_buf[idx[3:0]];
         last_byte = (idx == cmd_len_q - 5'd1);
      end else if (idx == 5'd0) begin
         tx_byte   = READ_CMD_BUFF;
      end else if (idx == 5'd1) begin
         last_byte = (rx_byte != CTS_READY) || (resp_len_q == 5'd0);
      end else begin
         last_byte = (idx == resp_len_q + 5'd1);
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= nxt;
   end

   // Next-state logic
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:        if (start)            nxt = ST_SEL;
         ST_SEL:         if (acc_ack)          nxt = ST_SS_ON;
         ST_SS_ON:       if (acc_ack)          nxt = ST_TX_WAIT;
         ST_TX_WAIT:     if (transmitterempty) nxt = ST_TX_WR;
         ST_TX_WR:       if (acc_ack)          nxt = ST_RX_WAIT;
         ST_RX_WAIT:     if (dataavailable)    nxt = ST_RX_RD;
         ST_RX_RD:       if (acc_ack)          nxt = last_byte ? ST_SS_OFF_WAIT : ST_TX_WAIT;
         ST_SS_OFF_WAIT: if (transmitterempty) nxt = ST_SS_OFF;
         ST_SS_OFF:      if (acc_ack)          nxt = poll_timeout ? ST_FIN : ST_GAP;
         ST_GAP: begin
            if (gap_done) begin
               if (frame == FR_CMD) nxt = cts_en_q ? ST_POLL_ON : ST_FIN;
               else                 nxt = cts_ok ? ST_FIN : ST_POLL_ON;
            end
         end
         ST_POLL_ON:     if (acc_ack)          nxt = ST_TX_WAIT;
         ST_FIN:                               nxt = ST_IDLE;
         default:                              nxt = ST_IDLE;
      endcase
   end

   // Register-port requests and status outputs decoded from the state
   always_comb begin
      acc_req   = 1'b0;
      acc_we    = 1'b0;
      acc_addr  = REG_RXDATA;
      acc_wdata = 16'h0000;
      busy      = (state != ST_IDLE);
      done      = (state == ST_FIN);
      case (state)
         ST_SEL: begin
            acc_req = 1'b1; acc_we = 1'b1; acc_addr = REG_SLAVESEL; acc_wdata = 16'h0001;
         end
         ST_SS_ON, ST_POLL_ON: begin
            acc_req = 1'b1; acc_we = 1'b1; acc_addr = REG_CONTROL; acc_wdata = CTRL_SSO;
         end
         ST_TX_WR: begin
            acc_req = 1'b1; acc_we = 1'b1; acc_addr = REG_TXDATA; acc_wdata = {8'h00, tx_byte};
         end
         ST_RX_RD: begin
            acc_req = 1'b1; acc_addr = REG_RXDATA;
         end
         ST_SS_OFF: begin
            acc_req = 1'b1; acc_we = 1'b1; acc_addr = REG_CONTROL;
         end
         default: ;
      endcase
   end

   // Sequence bookkeeping: sampled lengths, byte index, poll count, gap timer, error flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame      <= FR_CMD;
         idx        <= 5'd0;
         cmd_len_q  <= 5'd1;
         resp_len_q <= 5'd0;
         cts_en_q   <= 1'b0;
         cts_ok     <= 1'b0;
         poll_cnt   <= '0;
         gap_cnt    <= '0;
         err        <= 1'b0;
      end else begin
         gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cmd_len_q  <= clamp_len(cmd_len, BUF_DEPTH, 1'b1);
                  resp_len_q <= clamp_len(resp_len, BUF_DEPTH, 1'b0);
                  cts_en_q   <= cts_en;
                  err        <= 1'b0;
                  frame      <= FR_CMD;
                  idx        <= 5'd0;
                  cts_ok     <= 1'b0;
                  poll_cnt   <= '0;
               end
            end
            ST_RX_RD: begin
               if (acc_ack) begin
                  if (!last_byte) idx <= idx + 5'd1;
                  if ((frame == FR_POLL) && (idx == 5'd1)) cts_ok <= (rx_byte == CTS_READY);
               end
            end
            ST_SS_OFF: begin
               if (acc_ack && (frame == FR_POLL) && !cts_ok) begin
                  poll_cnt <= poll_cnt + 1'b1;
                  if (poll_timeout) err <= 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_done && (frame == FR_CMD) && cts_en_q) frame <= FR_POLL;
            end
            ST_POLL_ON: begin
               if (acc_ack) begin
                  idx    <= 5'd0;
                  cts_ok <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Host-side command buffer writes, accepted at any time
   always_ff @(posedge clk) begin
      if (cmd_wr) cmd_buf[cmd_addr] <= cmd_wdata;
   end

   // Response bytes follow the CTS byte, so buffer slot is byte index minus two
   always_ff @(posedge clk) begin
      if ((state == ST_RX_RD) && acc_ack && (frame == FR_POLL) && (idx >= 5'd2))
         resp_buf[4'(idx - 5'd2)] <= rx_byte;
   end

endmodule

// File: tb/tb_si4463_cmd_seq.sv
// tb/tb_si4463_cmd_seq.sv - self-checking bench for si4463_cmd_seq with an SPI master model
module tb_si4463_cmd_seq;

   localparam int MAXP = 3;
   localparam int GAPC = 8;
   localparam logic [19:0] ACC_R = 20'h00000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_wr;
   logic [3:0]  cmd_addr;
   logic [7:0]  cmd_wdata;
   logic [4:0]  cmd_len, resp_len;
   logic        cts_en, start;
   logic        busy, done, err;
   logic [3:0]  resp_addr;
   logic [7:0]  resp_rdata;
   logic        spi_select, write_n, read_n;
   logic [2:0]  mem_addr;
   logic [15:0] spi_wdata, spi_rdata;
   logic        dataavailable, transmitterempty;

   si4463_cmd_seq #(.BUF_DEPTH(16), .MAX_POLLS(MAXP), .GAP_CYCLES(GAPC)) dut (
      .clk(clk), .reset_n(reset_n), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_len(cmd_len), .resp_len(resp_len), .cts_en(cts_en),
      .start(start), .busy(busy), .done(done), .err(err), .resp_addr(resp_addr),
      .resp_rdata(resp_rdata), .spi_select(spi_select), .mem_addr(mem_addr),
      .write_n(write_n), .read_n(read_n), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
      .dataavailable(dataavailable), .transmitterempty(transmitterempty)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SPI master model state
   logic        tmt, rrdy, sso, slv;
   logic [7:0]  rxd, pend;
   int          dly;
   logic        ss_n;
   logic [7:0]  miso_q[$];
   logic [19:0] acc_log[$];
   logic [19:0] exp_log[$];
   int          low_run, done_cnt = 0, tx_cnt = 0;
   logic [2:0]  run_addr;
   logic [15:0] run_data;
   logic        run_we;

   assign transmitterempty = tmt;
   assign dataavailable    = rrdy;
   assign spi_rdata        = {8'h00, rxd};
   assign ss_n             = !(sso && slv);

   // SPI master behaviour, bus logging and access-timing checks, all sampled at negedge
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmt = 1'b1; rrdy = 1'b0; sso = 1'b0; slv = 1'b0; rxd = 8'h00; dly = 0; low_run = 0;
      end else begin
         if (dly > 0) begin
            dly--;
            if (dly == 0) begin tmt = 1'b1; rrdy = 1'b1; rxd = pend; end
         end
         if (done) done_cnt++;
         if (!write_n || !read_n) begin
            if (low_run == 0) begin
               check("acc_start", {30'd0, spi_select, !(write_n || read_n)}, 32'd2);
               run_addr = mem_addr; run_data = spi_wdata; run_we = !write_n;
               acc_log.push_back({!write_n, mem_addr, write_n ? 16'h0000 : spi_wdata});
               if (!write_n) begin
                  if (mem_addr == 3'd1) begin
                     tmt = 1'b0;
                     tx_cnt++;
                     if (miso_q.size() > 0) pend = miso_q.pop_front();
                     else pend = 8'($urandom);
                     dly = $urandom_range(2, 6);
                  end else if (mem_addr == 3'd3) sso = spi_wdata[10];
                  else if (mem_addr == 3'd5) slv = spi_wdata[0];
               end else if (mem_addr == 3'd0) rrdy = 1'b0;
            end else begin
               check("acc_hold", {spi_select, !write_n, mem_addr, spi_wdata},
                     {1'b1, run_we, run_addr, run_data});
            end
            low_run++;
         end else begin
            if (low_run != 0) begin
               check("acc_len", low_run, 2);
               check("acc_idle", spi_select, 0);
            end
            low_run = 0;
         end
      end
   end

   logic [7:0] cmd_img[16];
   logic [7:0] shadow[16];
   bit         sh_valid[16];
   logic [7:0] fixed_cmd[$];
   logic [7:0] fixed_resp[$];

   function automatic logic [19:0] acc_w(input int a, input int d);
      return {1'b1, 3'(a), 16'(d)};
   endfunction

   task automatic load_cmd();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         cmd_wr = 1'b1; cmd_addr = 4'(i); cmd_wdata = cmd_img[i];
      end
      @(negedge clk);
      cmd_wr = 1'b0;
   endtask

   // Builds the expected bus trace and MISO script from the protocol rules, runs one sequence, checks it
   task automatic run_seq(input int clen, input int rlen, input bit cts, input int nfail,
                          input int fail_cts, input int hold);
      int ec, er, d0, waited;
      bit eerr;
      logic [7:0] b;
      for (int i = 0; i < 16; i++)
         cmd_img[i] = (i < fixed_cmd.size()) ? fixed_cmd[i] : 8'($urandom);
      load_cmd();
      ec = (clen == 0) ? 1 : ((clen > 16) ? 16 : clen);
      er = (rlen > 16) ? 16 : rlen;
      eerr = cts && (nfail >= MAXP);
      exp_log.delete(); miso_q.delete();
      exp_log.push_back(acc_w(5, 1));
      exp_log.push_back(acc_w(3, 'h400));
      for (int i = 0; i < ec; i++) begin
         exp_log.push_back(acc_w(1, cmd_img[i]));
         exp_log.push_back(ACC_R);
         miso_q.push_back(8'($urandom));
      end
      exp_log.push_back(acc_w(3, 0));
      if (cts) begin
         for (int k = 0; k < MAXP; k++) begin
            exp_log.push_back(acc_w(3, 'h400));
            exp_log.push_back(acc_w(1, 'h44)); exp_log.push_back(ACC_R);
            exp_log.push_back(acc_w(1, 'hFF)); exp_log.push_back(ACC_R);
            miso_q.push_back(8'($urandom));
            if (k == nfail) miso_q.push_back(8'hFF);
            else if (fail_cts >= 0) miso_q.push_back(8'(fail_cts));
            else miso_q.push_back(8'($urandom_range(0, 254)));
            if (k == nfail) begin
               for (int j = 0; j < er; j++) begin
                  exp_log.push_back(acc_w(1, 'hFF)); exp_log.push_back(ACC_R);
                  b = (j < fixed_resp.size()) ? fixed_resp[j] : 8'($urandom);
                  miso_q.push_back(b);
                  shadow[j] = b; sh_valid[j] = 1'b1;
               end
            end
            exp_log.push_back(acc_w(3, 0));
            if (k == nfail) break;
         end
      end
      acc_log.delete();
      d0 = done_cnt;
      cmd_len = 5'(clen); resp_len = 5'(rlen); cts_en = cts; start = 1'b1;
      @(negedge clk); #1;
      check("busy_on", busy, 1);
      check("err_clr", err, 0);
      for (int h = 1; h < hold; h++) @(negedge clk);
      start = 1'b0;
      waited = 0;
      while ((done_cnt == d0) && (waited < 20000)) begin
         @(negedge clk); #1;
         waited++;
      end
      check("done_seen", 32'(done_cnt != d0), 1);
      repeat (5) @(negedge clk);
      #1;
      check("done_once", done_cnt - d0, 1);
      check("busy_off", busy, 0);
      check("err_val", err, eerr);
      check("acc_count", acc_log.size(), exp_log.size());
      for (int i = 0; (i < exp_log.size()) && (i < acc_log.size()); i++)
         check("acc_seq", acc_log[i], exp_log[i]);
      check("miso_used", miso_q.size(), 0);
      for (int i = 0; i < 16; i++) begin
         if (sh_valid[i]) begin
            resp_addr = 4'(i); #1;
            check("resp_buf", resp_rdata, shadow[i]);
         end
      end
      fixed_cmd.delete(); fixed_resp.delete();
   endtask

   initial begin
      int t0, waited;
      bit found;
      reset_n = 1'b0; cmd_wr = 1'b0; cmd_addr = 4'd0; cmd_wdata = 8'd0;
      cmd_len = 5'd0; resp_len = 5'd0; cts_en = 1'b0; start = 1'b0; resp_addr = 4'd0;
      for (int i = 0; i < 16; i++) sh_valid[i] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_sel", spi_select, 0);
      check("rst_wn", write_n, 1);
      check("rst_rn", read_n, 1);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", spi_wdata, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      fixed_cmd = '{8'h01};
      run_seq(1, 0, 1'b0, 0, -1, 1);

      fixed_cmd = '{8'h12, 8'h00, 8'h01, 8'h0A};
      fixed_resp = '{8'h5A, 8'hC3};
      run_seq(4, 2, 1'b1, 2, 0, 1);

      run_seq(2, 3, 1'b1, MAXP, 0, 1);
      run_seq(3, 1, 1'b1, 0, -1, 10);
      run_seq(0, 0, 1'b1, 0, -1, 1);
      run_seq(20, 17, 1'b1, 1, -1, 1);

      for (int r = 0; r < 6; r++)
         run_seq($urandom_range(0, 20), $urandom_range(0, 20), 1'($urandom_range(0, 1)),
                 $urandom_range(0, MAXP), -1, $urandom_range(1, 8));

      // Reset while the second command byte is on the bus
      for (int i = 0; i < 16; i++) cmd_img[i] = 8'($urandom);
      load_cmd();
      miso_q.delete();
      t0 = tx_cnt;
      cmd_len = 5'd4; resp_len = 5'd0; cts_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0; waited = 0;
      while (!found && (waited < 2000)) begin
         @(negedge clk); #1;
         waited++;
         if ((tx_cnt - t0 == 2) && !write_n) found = 1'b1;
      end
      check("rst_found", 32'(found), 1);
      reset_n = 1'b0;
      #1;
      check("mid_wn", write_n, 1);
      check("mid_rn", read_n, 1);
      check("mid_sel", spi_select, 0);
      check("mid_busy", busy, 0);
      check("mid_ssn", ss_n, 1);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("post_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
